// File: rtl/tb_segment_ctrl.sv
// Traceback segment controller: tracks survivor-memory fill, launches windowed
// and final tracebacks for one frame, and hands decoded words to the sink.
module tb_segment_ctrl #(
    parameter int W_TB_LEN = 6,
    parameter int W_HALF   = 32,
    parameter int W_FULL   = 64,
    parameter int W_FLEN   = 16
) (
    input  logic                clk_i,
    input  logic                rst_an_i,
    input  logic                rst_sync_i,
    input  logic                frame_start_i,
    input  logic [W_FLEN-1:0]   frame_len_i,
    input  logic [1:0]          register_num_cfg_i,
    input  logic                terminated_i,
    input  logic                stage_wr_i,
    input  logic [5:0]          best_state_i,
    output logic                acs_stall_o,
    output logic [W_TB_LEN-1:0] sm_wr_addr_o,
    output logic                tb_segment_start_o,
    output logic [1:0]          tb_register_num_o,
    output logic [5:0]          tb_start_state_o,
    output logic [W_TB_LEN-1:0] tb_start_addr_o,
    output logic [W_TB_LEN:0]   tb_len_o,
    output logic                tb_decoding_end_o,
    input  logic                tb_busy_i,
    input  logic                tb_bits_valid_i,
    input  logic [W_HALF-1:0]   tb_half_bits_i,
    input  logic [W_FULL-1:0]   tb_full_bits_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [W_FULL-1:0]   out_bits_o,
    output logic [6:0]          out_nbits_o,
    output logic                out_last_o,
    output logic                busy_o
);
    localparam int                DEPTH  = 1 << W_TB_LEN;
    localparam int                WIN    = 2 * W_HALF;
    localparam logic [W_FLEN-1:0] DEPTH_F = W_FLEN'(DEPTH);
    localparam logic [W_FLEN-1:0] WIN_F   = W_FLEN'(WIN);
    localparam logic [W_FLEN-1:0] HALF_F  = W_FLEN'(W_HALF);
    localparam logic [W_FLEN-1:0] FULL_F  = W_FLEN'(W_FULL);
    localparam logic [W_TB_LEN:0] WIN_L   = (W_TB_LEN+1)'(WIN);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t                r_state, w_state_next;
    logic [W_FLEN-1:0]     r_wr_cnt, r_dec_cnt, r_frame_len, w_avail;
    logic                  r_terminated, r_is_final;
    logic [1:0]            r_reg_num;
    logic [W_TB_LEN-1:0]   r_tb_addr, w_launch_addr;
    logic [W_TB_LEN:0]     r_tb_len, w_launch_len;
    logic                  r_tb_end;
    logic [5:0]            r_tb_state, w_launch_state;
    logic                  r_out_valid, r_out_last;
    logic [W_FULL-1:0]     r_out_bits, w_full_mask;
    logic [6:0]            r_out_nbits;
    logic                  w_active, w_stall, w_write, w_launch_ok;
    logic                  w_win_ok, w_final_ok, w_launching, w_result;

    assign w_avail     = r_wr_cnt - r_dec_cnt;
    assign w_active    = (r_state == S_RUN) || (r_state == S_LAUNCH) || (r_state == S_WAIT);
    assign w_stall     = !w_active || (w_avail >= DEPTH_F) || (r_wr_cnt == r_frame_len);
    assign w_write     = stage_wr_i && !w_stall;
    assign w_launch_ok = !tb_busy_i && !r_out_valid;
    assign w_final_ok  = (r_wr_cnt == r_frame_len) && (w_avail <= FULL_F);
    assign w_win_ok    = (w_avail >= WIN_F);
    assign w_launching = (r_state == S_LAUNCH);
    assign w_result    = (r_state == S_WAIT) && tb_bits_valid_i;

    assign w_launch_addr  = r_wr_cnt[W_TB_LEN-1:0] - W_TB_LEN'(1);
    assign w_launch_len   = r_is_final ? w_avail[W_TB_LEN:0] : WIN_L;
    assign w_launch_state = (r_is_final && r_terminated) ? 6'd0 : best_state_i;

    // Final-result mask keeps only the stages that were actually traced.
    generate
        for (genvar gi = 0; gi < W_FULL; gi++) begin : g_mask
            assign w_full_mask[gi] = (r_tb_len > (W_TB_LEN+1)'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (frame_start_i) w_state_next = S_RUN;
            S_RUN:    if (w_launch_ok && (w_final_ok || w_win_ok)) w_state_next = S_LAUNCH;
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT:   if (tb_bits_valid_i) w_state_next = r_is_final ? S_DONE : S_RUN;
            S_DONE:   if (!r_out_valid) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_state      <= S_IDLE;
            r_is_final   <= 1'b0;
            r_wr_cnt     <= '0;
            r_dec_cnt    <= '0;
            r_frame_len  <= '0;
            r_terminated <= 1'b0;
            r_reg_num    <= '0;
        end else if (rst_sync_i) begin
            r_state      <= S_IDLE;
            r_is_final   <= 1'b0;
            r_wr_cnt     <= '0;
            r_dec_cnt    <= '0;
            r_frame_len  <= '0;
            r_terminated <= 1'b0;
            r_reg_num    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_RUN && w_state_next == S_LAUNCH)
                r_is_final <= w_final_ok;
            if (r_state == S_IDLE && frame_start_i) begin
                r_frame_len  <= frame_len_i;
                r_terminated <= terminated_i;
                r_reg_num    <= register_num_cfg_i;
                r_wr_cnt     <= '0;
                r_dec_cnt    <= '0;
            end else begin
                if (w_write)
                    r_wr_cnt <= r_wr_cnt + W_FLEN'(1);
                if (w_result)
                    r_dec_cnt <= r_is_final ? r_frame_len : r_dec_cnt + HALF_F;
            end
        end
    end

    // Launch operands are live during the launch cycle and held afterwards.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_tb_addr  <= '0;
            r_tb_len   <= '0;
            r_tb_end   <= 1'b0;
            r_tb_state <= '0;
        end else if (rst_sync_i) begin
            r_tb_addr  <= '0;
            r_tb_len   <= '0;
            r_tb_end   <= 1'b0;
            r_tb_state <= '0;
        end else if (w_launching) begin
            r_tb_addr  <= w_launch_addr;
            r_tb_len   <= w_launch_len;
            r_tb_end   <= r_is_final;
            r_tb_state <= w_launch_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_nbits <= '0;
            r_out_last  <= 1'b0;
        end else if (rst_sync_i) begin
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_nbits <= '0;
            r_out_last  <= 1'b0;
        end else if (w_result) begin
            r_out_valid <= 1'b1;
            if (r_is_final) begin
                r_out_bits  <= tb_full_bits_i & w_full_mask;
                r_out_nbits <= 7'(r_tb_len);
                r_out_last  <= 1'b1;
            end else begin
                r_out_bits  <= W_FULL'(tb_half_bits_i);
                r_out_nbits <= 7'(W_HALF);
                r_out_last  <= 1'b0;
            end
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign acs_stall_o        = w_stall;
    assign sm_wr_addr_o       = r_wr_cnt[W_TB_LEN-1:0];
    assign tb_segment_start_o = w_launching;
    assign tb_register_num_o  = r_reg_num;
    assign tb_start_addr_o    = w_launching ? w_launch_addr  : r_tb_addr;
    assign tb_len_o           = w_launching ? w_launch_len   : r_tb_len;
    assign tb_decoding_end_o  = w_launching ? r_is_final     : r_tb_end;
    assign tb_start_state_o   = w_launching ? w_launch_state : r_tb_state;
    assign out_valid_o        = r_out_valid;
    assign out_bits_o         = r_out_bits;
    assign out_nbits_o        = r_out_nbits;
    assign out_last_o         = r_out_last;
    assign busy_o             = (r_state != S_IDLE);
endmodule

// File: tb/tb_tb_segment_ctrl.sv
// Directed bench for tb_segment_ctrl: a frame-level launch plan and word queue
// are checked against the DUT every cycle, plus literal spot checks per frame.
module tb_tb_segment_ctrl;
    logic        clk_i = 1'b0, rst_an_i = 1'b0, rst_sync_i = 1'b0, frame_start_i = 1'b0;
    logic [15:0] frame_len_i = '0;
    logic [1:0]  register_num_cfg_i = '0;
    logic        terminated_i = 1'b0, stage_wr_i = 1'b0;
    logic [5:0]  best_state_i = '0;
    logic        acs_stall_o, tb_segment_start_o, tb_decoding_end_o;
    logic [5:0]  sm_wr_addr_o, tb_start_state_o, tb_start_addr_o;
    logic [1:0]  tb_register_num_o;
    logic [6:0]  tb_len_o, out_nbits_o;
    logic        tb_busy_i = 1'b0, tb_bits_valid_i = 1'b0;
    logic [31:0] tb_half_bits_i = '0;
    logic [63:0] tb_full_bits_i = '0, out_bits_o;
    logic        out_valid_o, out_ready_i = 1'b1, out_last_o, busy_o;

    tb_segment_ctrl dut (
        .clk_i(clk_i), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i),
        .frame_start_i(frame_start_i), .frame_len_i(frame_len_i),
        .register_num_cfg_i(register_num_cfg_i), .terminated_i(terminated_i),
        .stage_wr_i(stage_wr_i), .best_state_i(best_state_i),
        .acs_stall_o(acs_stall_o), .sm_wr_addr_o(sm_wr_addr_o),
        .tb_segment_start_o(tb_segment_start_o), .tb_register_num_o(tb_register_num_o),
        .tb_start_state_o(tb_start_state_o), .tb_start_addr_o(tb_start_addr_o),
        .tb_len_o(tb_len_o), .tb_decoding_end_o(tb_decoding_end_o),
        .tb_busy_i(tb_busy_i), .tb_bits_valid_i(tb_bits_valid_i),
        .tb_half_bits_i(tb_half_bits_i), .tb_full_bits_i(tb_full_bits_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_bits_o(out_bits_o),
        .out_nbits_o(out_nbits_o), .out_last_o(out_last_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame plan: the launches the frame must produce, derived from fill arithmetic.
    int plan_addr[16], plan_len[16];
    bit plan_end[16];
    int n_plan = 0, launch_cnt = 0;
    int m_flen = 0;
    bit m_term = 1'b0;

    typedef struct { logic [63:0] bits; int nbits; bit last; } word_t;
    word_t exp_w[$];

    task automatic build_plan(input int flen);
        int wr, dec;
        n_plan = 0;
        dec = 0;
        wr = (flen < 64) ? flen : 64;
        forever begin
            plan_addr[n_plan] = (wr - 1) % 64;
            if (wr == flen) begin
                plan_len[n_plan] = wr - dec;
                plan_end[n_plan] = 1'b1;
                n_plan++;
                break;
            end
            plan_len[n_plan] = 64;
            plan_end[n_plan] = 1'b0;
            n_plan++;
            dec += 32;
            wr = (flen < dec + 64) ? flen : dec + 64;
        end
    endtask

    // Fill model: stages written and decoded as plain counts.
    int  m_wr = 0, m_dec = 0;
    bit  m_started = 1'b0, resp_final = 1'b0;
    bit  m_stall;
    assign m_stall = !m_started || (m_wr - m_dec) >= 64 || (m_wr == m_flen);

    always @(posedge clk_i) begin
        if (!rst_an_i || rst_sync_i) begin
            m_wr <= 0; m_dec <= 0; m_started <= 1'b0;
        end else if (frame_start_i && !m_started) begin
            m_wr <= 0; m_dec <= 0; m_started <= 1'b1;
        end else begin
            if (stage_wr_i && !m_stall) m_wr <= m_wr + 1;
            if (tb_bits_valid_i && m_started) begin
                m_dec <= resp_final ? m_flen : m_dec + 32;
                if (resp_final) m_started <= 1'b0;
            end
        end
    end

    logic [63:0] pv_bits;
    logic [6:0]  pv_nbits;
    logic        pv_last, pv_valid = 1'b0, pv_ready = 1'b0;

    always @(negedge clk_i) begin
        if (rst_an_i) begin
            chk("acs_stall", 64'(acs_stall_o), 64'(m_stall));
            chk("sm_wr_addr", 64'(sm_wr_addr_o), 64'(m_wr % 64));
            if (tb_segment_start_o) begin
                chk("launch_while_valid", 64'(out_valid_o), 64'd0);
                if (launch_cnt >= n_plan) begin
                    chk("unplanned_launch", 64'(launch_cnt), 64'(n_plan));
                end else begin
                    chk("launch_addr", 64'(tb_start_addr_o), 64'(plan_addr[launch_cnt]));
                    chk("launch_len", 64'(tb_len_o), 64'(plan_len[launch_cnt]));
                    chk("launch_end", 64'(tb_decoding_end_o), 64'(plan_end[launch_cnt]));
                    chk("launch_state", 64'(tb_start_state_o),
                        (plan_end[launch_cnt] && m_term) ? 64'd0 : 64'(best_state_i));
                end
                launch_cnt++;
            end
            if (pv_valid && !pv_ready && out_valid_o) begin
                chk("hold_bits", out_bits_o, pv_bits);
                chk("hold_nbits", 64'(out_nbits_o), 64'(pv_nbits));
                chk("hold_last", 64'(out_last_o), 64'(pv_last));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_w.size() == 0) begin
                    chk("unexpected_word", 64'(exp_w.size()), 64'd1);
                end else begin
                    word_t w;
                    w = exp_w.pop_front();
                    chk("word_bits", out_bits_o, w.bits);
                    chk("word_nbits", 64'(out_nbits_o), 64'(w.nbits));
                    chk("word_last", 64'(out_last_o), 64'(w.last));
                end
            end
        end
        pv_valid = out_valid_o; pv_ready = out_ready_i;
        pv_bits = out_bits_o; pv_nbits = out_nbits_o; pv_last = out_last_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 3000) begin tick(); n++; end
        chk("idle_timeout", 64'(busy_o), 64'd0);
    endtask

    task automatic start_frame(input int flen, input bit term, input logic [1:0] rc, input logic [5:0] bs);
        build_plan(flen);
        launch_cnt = 0;
        m_flen = flen; m_term = term; best_state_i = bs;
        frame_len_i = 16'(flen); terminated_i = term; register_num_cfg_i = rc;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic run_frame(input int flen, input bit term, input logic [1:0] rc, input logic [5:0] bs,
                             input bit stall_test, input int lit_addr, input int lit_len, input int lit_state);
        logic [63:0] full, mask;
        word_t w;
        start_frame(flen, term, rc, bs);
        for (int k = 0; k < n_plan; k++) begin
            int n = 0;
            while (launch_cnt <= k && n < 3000) begin tick(); n++; end
            if (launch_cnt <= k) begin
                chk("launch_timeout", 64'(launch_cnt), 64'(k + 1));
                return;
            end
            if (plan_end[k]) begin
                chk("lit_final_addr", 64'(tb_start_addr_o), 64'(lit_addr));
                chk("lit_final_len", 64'(tb_len_o), 64'(lit_len));
                chk("lit_final_state", 64'(tb_start_state_o), 64'(lit_state));
                chk("lit_final_end", 64'(tb_decoding_end_o), 64'd1);
                chk("lit_reg_num", 64'(tb_register_num_o), 64'(rc));
            end
            if (stall_test && k == 0) out_ready_i = 1'b0;
            tb_busy_i = 1'b1;
            repeat (3) tick();
            tb_half_bits_i = $urandom;
            full = {$urandom, $urandom} | 64'hF0F0_0000_0000_00E0;
            tb_full_bits_i = full;
            if (plan_end[k]) begin
                mask = (plan_len[k] >= 64) ? '1 : ((64'd1 << plan_len[k]) - 64'd1);
                w.bits = full & mask; w.nbits = plan_len[k]; w.last = 1'b1;
            end else begin
                w.bits = {32'd0, tb_half_bits_i}; w.nbits = 32; w.last = 1'b0;
            end
            exp_w.push_back(w);
            resp_final = plan_end[k];
            tb_bits_valid_i = 1'b1;
            tick();
            tb_bits_valid_i = 1'b0;
            tb_busy_i = 1'b0;
            if (plan_end[k]) begin
                chk("lit_out_nbits", 64'(out_nbits_o), 64'(lit_len));
                chk("lit_out_last", 64'(out_last_o), 64'd1);
                if (lit_len < 64) chk("lit_bits_above_len", out_bits_o >> lit_len, 64'd0);
            end
            if (stall_test && k == 0) begin
                repeat (40) tick();
                chk("full_stall", 64'(acs_stall_o), 64'd1);
                chk("full_wr_addr", 64'(sm_wr_addr_o), 64'd32);
                chk("full_no_launch", 64'(launch_cnt), 64'd1);
                chk("full_valid_held", 64'(out_valid_o), 64'd1);
                out_ready_i = 1'b1;
            end
        end
        wait_idle();
        chk("words_drained", 64'(exp_w.size()), 64'd0);
        $display("frame len=%0d term=%0d launches=%0d checks=%0d errors=%0d",
                 flen, term, launch_cnt, n_checks, n_errors);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_an_i = 1'b1;
        stage_wr_i = 1'b1;
        tick();
        chk("rst_stall", 64'(acs_stall_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_len", 64'(tb_len_o), 64'd0);

        run_frame(64, 1'b1, 2'd1, 6'd33, 1'b0, 63, 64, 0);
        run_frame(96, 1'b0, 2'd2, 6'd45, 1'b0, 31, 64, 45);
        run_frame(200, 1'b0, 2'd3, 6'd12, 1'b1, 7, 40, 12);
        run_frame(5, 1'b1, 2'd1, 6'd9, 1'b0, 4, 5, 0);

        // Abort mid-traceback, then a late result must be ignored.
        start_frame(96, 1'b0, 2'd2, 6'd21);
        begin
            int n = 0;
            while (launch_cnt == 0 && n < 3000) begin tick(); n++; end
            chk("abort_launch_seen", 64'(launch_cnt), 64'd1);
        end
        tb_busy_i = 1'b1;
        repeat (2) tick();
        rst_sync_i = 1'b1;
        tick();
        rst_sync_i = 1'b0;
        tb_busy_i = 1'b0;
        n_plan = 0; launch_cnt = 0;
        exp_w.delete();
        chk("abort_stall", 64'(acs_stall_o), 64'd1);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_valid", 64'(out_valid_o), 64'd0);
        chk("abort_tb_len", 64'(tb_len_o), 64'd0);
        chk("abort_tb_addr", 64'(tb_start_addr_o), 64'd0);
        chk("abort_tb_end", 64'(tb_decoding_end_o), 64'd0);
        chk("abort_reg_num", 64'(tb_register_num_o), 64'd0);
        resp_final = 1'b0;
        tb_half_bits_i = 32'hDEAD_BEEF;
        tb_bits_valid_i = 1'b1;
        tick();
        tb_bits_valid_i = 1'b0;
        tick();
        chk("late_result_ignored", 64'(out_valid_o), 64'd0);
        chk("late_result_idle", 64'(busy_o), 64'd0);

        run_frame(64, 1'b1, 2'd3, 6'd50, 1'b0, 63, 64, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
